// File: rtl/store_buffer_if.sv
// Memory-side write port of the store buffer: a request/acknowledge handshake
// that carries one word-aligned, byte-masked write per accepted request.
interface store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic              memReq;
  logic [AW-1:0]     memAddr;
  logic [DW-1:0]     memData;
  logic [DW/8-1:0]   memMask;
  logic              memAck;

  modport master (
    output memReq,
    output memAddr,
    output memData,
    output memMask,
    input  memAck
  );

  modport slave (
    input  memReq,
    input  memAddr,
    input  memData,
    input  memMask,
    output memAck
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write buffer between the MEM stage and data memory: in-order drain,
// youngest-entry load forwarding, partial-overlap conflict detection and fencing.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       resetIn,

  input  logic                       storeValid,
  input  logic [AW-1:0]              storeAddr,
  input  logic [DW-1:0]              storeData,
  input  logic [DW/8-1:0]            storeMask,
  output logic                       storeReady,

  input  logic                       loadValid,
  input  logic [AW-1:0]              loadAddr,
  input  logic [DW/8-1:0]            loadMask,
  output logic                       loadHit,
  output logic [DW-1:0]              loadHitData,
  output logic                       loadConflict,

  input  logic                       flushReq,
  output logic                       drained,

  store_buffer_if.master             memPort,

  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int MW = DW / 8;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  logic [AW-1:0]  r_addr [DEPTH];
  logic [DW-1:0]  r_data [DEPTH];
  logic [MW-1:0]  r_mask [DEPTH];
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [CW-1:0]  r_count;
  state_t         r_state;
  logic           r_drained;

  logic           w_push;
  logic           w_pop;
  logic           w_memReq;
  logic [CW-1:0]  w_countNext;
  logic           w_fwdFound;
  logic [PW-1:0]  w_fwdIdx;
  logic [PW-1:0]  w_slot;
  logic           w_fwdCovers;
  logic           w_unused;

  // Readiness comes only from registered state, so a full buffer never
  // accepts a store in the same cycle that the head is being acked.
  assign storeReady  = (r_state == RUN) && (r_count < CW'(DEPTH));
  assign w_memReq    = (r_count != '0);
  assign w_push      = storeValid && storeReady;
  assign w_pop       = w_memReq && memPort.memAck;
  assign w_countNext = r_count + CW'(w_push) - CW'(w_pop);

  assign memPort.memReq  = w_memReq;
  assign memPort.memAddr = r_addr[r_head];
  assign memPort.memData = r_data[r_head];
  assign memPort.memMask = r_mask[r_head];

  assign count   = r_count;
  assign empty   = (r_count == '0);
  assign drained = r_drained;

  assign w_unused = ^{storeAddr[1:0], loadAddr[1:0]};

  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_mask[i] <= '0;
      end
    end else if (w_push) begin
      r_addr[r_tail] <= {storeAddr[AW-1:2], 2'b00};
      r_data[r_tail] <= storeData;
      r_mask[r_tail] <= storeMask;
    end
  end

  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      r_count <= w_countNext;
    end
  end

  // A fence on an already-empty buffer completes immediately; otherwise the
  // buffer stops accepting stores until the last pending entry is acked.
  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      r_state   <= RUN;
      r_drained <= 1'b0;
    end else begin
      r_drained <= 1'b0;
      case (r_state)
        RUN: begin
          if (flushReq) begin
            if (r_count == '0) begin
              r_drained <= 1'b1;
            end else begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_countNext == '0) begin
            r_state   <= RUN;
            r_drained <= 1'b1;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // Walk entries oldest to youngest so the last match wins.
  always_comb begin
    w_fwdFound = 1'b0;
    w_fwdIdx   = '0;
    w_slot     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_slot = r_head + PW'(i);
      if ((CW'(i) < r_count) && (r_addr[w_slot][AW-1:2] == loadAddr[AW-1:2])) begin
        w_fwdFound = 1'b1;
        w_fwdIdx   = w_slot;
      end
    end
  end

  assign w_fwdCovers  = ((r_mask[w_fwdIdx] & loadMask) == loadMask);
  assign loadHit      = loadValid && w_fwdFound && w_fwdCovers;
  assign loadConflict = loadValid && w_fwdFound && !w_fwdCovers;
  assign loadHitData  = loadHit ? r_data[w_fwdIdx] : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a table of stimulus rows with explicit
// expectations, backed by a queue scoreboard modelling the pending stores.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int MW    = DW / 8;

  logic            clk = 1'b0;
  logic            resetIn;
  logic            storeValid;
  logic [AW-1:0]   storeAddr;
  logic [DW-1:0]   storeData;
  logic [MW-1:0]   storeMask;
  logic            storeReady;
  logic            loadValid;
  logic [AW-1:0]   loadAddr;
  logic [MW-1:0]   loadMask;
  logic            loadHit;
  logic [DW-1:0]   loadHitData;
  logic            loadConflict;
  logic            flushReq;
  logic            drained;
  logic [$clog2(DEPTH):0] count;
  logic            empty;

  store_buffer_if #(.AW(AW), .DW(DW)) memBus ();

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .resetIn      (resetIn),
    .storeValid   (storeValid),
    .storeAddr    (storeAddr),
    .storeData    (storeData),
    .storeMask    (storeMask),
    .storeReady   (storeReady),
    .loadValid    (loadValid),
    .loadAddr     (loadAddr),
    .loadMask     (loadMask),
    .loadHit      (loadHit),
    .loadHitData  (loadHitData),
    .loadConflict (loadConflict),
    .flushReq     (flushReq),
    .drained      (drained),
    .memPort      (memBus),
    .count        (count),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
  } entry_t;

  typedef struct {
    logic          sv;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    logic [MW-1:0] sm;
    logic          ack;
    logic          lv;
    logic [AW-1:0] la;
    logic [MW-1:0] lm;
    logic          fl;
    int            expCount;
    logic          expHit;
    logic          expConf;
  } vec_t;

  entry_t sb[$];
  vec_t   vecs[$];
  int     total = 0;
  int     bad   = 0;
  logic   mDrain   = 1'b0;
  logic   mDrained = 1'b0;

  function automatic vec_t mk(logic sv, logic [AW-1:0] sa, logic [DW-1:0] sd, logic [MW-1:0] sm,
                              logic ack, logic lv, logic [AW-1:0] la, logic [MW-1:0] lm,
                              logic fl, int expCount, logic expHit, logic expConf);
    vec_t v;
    v.sv = sv; v.sa = sa; v.sd = sd; v.sm = sm; v.ack = ack;
    v.lv = lv; v.la = la; v.lm = lm; v.fl = fl;
    v.expCount = expCount; v.expHit = expHit; v.expConf = expConf;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare every observable output against the scoreboard's view.
  task automatic checkOutput();
    entry_t        e;
    logic          found;
    logic          expHit;
    logic          expConf;
    found = 1'b0;
    e     = '0;
    check("count", 64'(count), 64'(sb.size()));
    check("empty", 64'(empty), 64'(sb.size() == 0));
    check("memReq", 64'(memBus.memReq), 64'(sb.size() != 0));
    check("storeReady", 64'(storeReady), 64'(!mDrain && sb.size() < DEPTH));
    check("drained", 64'(drained), 64'(mDrained));
    if (sb.size() != 0) begin
      check("memAddr", 64'(memBus.memAddr), 64'(sb[0].addr));
      check("memData", 64'(memBus.memData), 64'(sb[0].data));
      check("memMask", 64'(memBus.memMask), 64'(sb[0].mask));
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (!found && sb[i].addr[AW-1:2] == loadAddr[AW-1:2]) begin
        e     = sb[i];
        found = 1'b1;
      end
    end
    expHit  = loadValid && found && ((e.mask & loadMask) == loadMask);
    expConf = loadValid && found && !((e.mask & loadMask) == loadMask);
    check("loadHit", 64'(loadHit), 64'(expHit));
    check("loadConflict", 64'(loadConflict), 64'(expConf));
    check("loadHitData", 64'(loadHitData), expHit ? 64'(e.data) : 64'd0);
  endtask

  // Advance the scoreboard across the coming rising edge.
  task automatic modelEdge();
    logic push;
    logic pop;
    int   nsize;
    logic nDrained;
    push     = storeValid && !mDrain && (sb.size() < DEPTH);
    pop      = (sb.size() != 0) && memBus.memAck;
    nsize    = sb.size() + int'(push) - int'(pop);
    nDrained = 1'b0;
    if (!mDrain) begin
      if (flushReq) begin
        if (sb.size() == 0) nDrained = 1'b1;
        else mDrain = 1'b1;
      end
    end else if (nsize == 0) begin
      mDrain   = 1'b0;
      nDrained = 1'b1;
    end
    if (pop) void'(sb.pop_front());
    if (push) sb.push_back({{storeAddr[AW-1:2], 2'b00}, storeData, storeMask});
    mDrained = nDrained;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    storeValid    = v.sv;
    storeAddr     = v.sa;
    storeData     = v.sd;
    storeMask     = v.sm;
    memBus.memAck = v.ack;
    loadValid     = v.lv;
    loadAddr      = v.la;
    loadMask      = v.lm;
    flushReq      = v.fl;
    #1;
    checkOutput();
    check($sformatf("row%0d.count", idx), 64'(count), 64'(v.expCount));
    check($sformatf("row%0d.hit", idx), 64'(loadHit), 64'(v.expHit));
    check($sformatf("row%0d.conflict", idx), 64'(loadConflict), 64'(v.expConf));
    modelEdge();
  endtask

  initial begin
    // basic push / ack
    vecs.push_back(mk(1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // fill, dropped fifth push, in-order drain
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 32'h400 + 32'(4 * i), 32'h4000_0000 + 32'(i), 4'hF, 0, 0, 0, 0, 0, i, 0, 0));
    vecs.push_back(mk(1, 32'h410, 32'hBAD0_0000, 4'hF, 0, 0, 0, 0, 0, 4, 0, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 4 - i, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // wrap with simultaneous push and pop (odd low address bits must be dropped)
    vecs.push_back(mk(1, 32'h500, 32'h5000_0000, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 6; i++)
      vecs.push_back(mk(1, 32'h500 + 32'(4 * i) + 32'(i % 4), 32'h5000_0000 + 32'(i), 4'hF, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // forwarding: youngest hit, partial conflict, miss, load disabled
    vecs.push_back(mk(1, 32'h200, 32'h11111111, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h200, 32'h22222222, 4'hF, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h202, 4'hF, 0, 2, 1, 0));
    vecs.push_back(mk(1, 32'h300, 32'h33333333, 4'h3, 0, 0, 0, 0, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h300, 4'hF, 0, 3, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h301, 4'h3, 0, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h600, 4'hF, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h200, 4'hF, 0, 3, 0, 0));
    // fence with 3 pending, store blocked during drain
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0));
    vecs.push_back(mk(1, 32'h800, 32'h8888_8888, 4'hF, 0, 0, 0, 0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // fence on empty buffer
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // conflict on head while it is acked, clears next cycle
    vecs.push_back(mk(1, 32'h700, 32'h0000_0077, 4'h1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h700, 4'hF, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h700, 4'hF, 0, 0, 0, 0));
    // second flush during drain is ignored
    vecs.push_back(mk(1, 32'h900, 32'h9000_0000, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h904, 32'h9000_0001, 4'hF, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // two entries pending ahead of the asynchronous reset
    vecs.push_back(mk(1, 32'hA00, 32'hA000_0000, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'hA04, 32'hA000_0001, 4'hF, 0, 0, 0, 0, 0, 1, 0, 0));

    resetIn       = 1'b0;
    storeValid    = 1'b0;
    storeAddr     = '0;
    storeData     = '0;
    storeMask     = '0;
    loadValid     = 1'b0;
    loadAddr      = '0;
    loadMask      = '0;
    flushReq      = 1'b0;
    memBus.memAck = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.storeReady", 64'(storeReady), 64'd1);
    check("rst.empty", 64'(empty), 64'd1);
    check("rst.count", 64'(count), 64'd0);
    check("rst.memReq", 64'(memBus.memReq), 64'd0);
    check("rst.memAddr", 64'(memBus.memAddr), 64'd0);
    check("rst.memData", 64'(memBus.memData), 64'd0);
    check("rst.memMask", 64'(memBus.memMask), 64'd0);
    check("rst.drained", 64'(drained), 64'd0);
    check("rst.loadHit", 64'(loadHit), 64'd0);
    check("rst.loadConflict", 64'(loadConflict), 64'd0);
    resetIn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end

    // Asynchronous reset between edges with two entries pending.
    @(negedge clk);
    storeValid    = 1'b0;
    loadValid     = 1'b0;
    flushReq      = 1'b0;
    memBus.memAck = 1'b0;
    #1;
    check("preReset.memReq", 64'(memBus.memReq), 64'd1);
    check("preReset.count", 64'(count), 64'd2);
    check("preReset.memAddr", 64'(memBus.memAddr), 64'h0000_0A00);
    resetIn = 1'b0;
    #1;
    check("midReset.memReq", 64'(memBus.memReq), 64'd0);
    check("midReset.count", 64'(count), 64'd0);
    check("midReset.empty", 64'(empty), 64'd1);
    check("midReset.memData", 64'(memBus.memData), 64'd0);
    sb.delete();
    mDrain   = 1'b0;
    mDrained = 1'b0;
    @(negedge clk);
    resetIn = 1'b1;

    applyStimulus(mk(1, 32'hB00, 32'hB000_000B, 4'hC, 0, 0, 0, 0, 0, 0, 0, 0), 100);
    applyStimulus(mk(0, 0, 0, 0, 1, 1, 32'hB00, 4'h4, 0, 1, 1, 0), 101);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 102);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the ALU_MEM stage and the data memory port. It accepts word stores from the pipeline in one cycle and drains them in order to a handshaked memory port that may take several cycles per write. Loads that hit a pending store get their data forwarded from the buffer; loads that overlap a pending store only partially raise a stall. The block replaces the direct store path into `ram`, so stores no longer stall the pipeline while memory latency is hidden.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; must be a power of two, at least 2.
- `AW`, 32: address width in bits.
- `DW`, 32: data width in bits; the mask width is `DW/8`.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `resetIn`  in  1  reset, asynchronous and active-low; clears all entries and state.
- `storeValid`  in  1  the MEM stage presents a store this cycle.
- `storeAddr`  in  AW  byte address of the store; bits [1:0] are ignored and the store is word-aligned.
- `storeData`  in  DW  store data, already lane-aligned.
- `storeMask`  in  DW/8  byte enables.
- `storeReady`  out  1  the buffer accepts a store this cycle.
- `loadValid`  in  1  the MEM stage performs a load this cycle.
- `loadAddr`  in  AW  load byte address, word-compared.
- `loadMask`  in  DW/8  bytes the load needs.
- `loadHit`  out  1  the youngest matching entry covers every byte in `loadMask`.
- `loadHitData`  out  DW  data of that entry.
- `loadConflict`  out  1  a matching entry exists but does not cover `loadMask`; the pipeline must stall.
- `flushReq`  in  1  one-cycle pulse that requests a full drain (fence).
- `drained`  out  1  one-cycle pulse when a requested drain completes.
- `memReq`  out  1  a write request to memory is pending.
- `memAddr`  out  AW  head entry address, with bits [1:0] forced to 0.
- `memData`  out  DW  head entry data.
- `memMask`  out  DW/8  head entry byte enables.
- `memAck`  in  1  memory accepts the head write this cycle.
- `count`  out  log2(DEPTH)+1  number of valid entries.
- `empty`  out  1  `count` == 0.

## Operation
- Storage is a circular FIFO with head pointer, tail pointer and `count`. Both pointers wrap modulo `DEPTH`.
- Push: occurs when `storeValid && storeReady`. The store is written at the tail and the tail advances.
- Pop: occurs when `memReq && memAck`. The head advances.
- Push and pop in the same cycle leave `count` unchanged.
- Memory side:
  - `memReq` = !`empty`. `memAddr`, `memData` and `memMask` always show the head slot.
  - These outputs are held stable while `memReq` is high and `memAck` is low.
- Load forwarding is combinational over the current valid entries; a store pushed in the same cycle is not included.
  - Matching uses `loadAddr[AW-1:2]`. Among matching entries, the youngest one is selected.
  - If its mask covers `loadMask`: `loadHit`=1 and `loadHitData` = that entry's data.
  - Otherwise: `loadConflict`=1.
  - With no match, or with `loadValid`=0: both flags are 0 and `loadHitData`=0.
  - Older entries are never merged into the result.
- FSM with two states:
  - RUN: `storeReady` = (`count` < `DEPTH`). `flushReq` moves to DRAIN; if the buffer is already empty, `drained` pulses in the next cycle and the state stays RUN.
  - DRAIN: `storeReady`=0. When `count` becomes 0, return to RUN with `drained`=1 for exactly one cycle.
  - `flushReq` received while in DRAIN is ignored.
- Reset values: `storeReady`=1, `empty`=1, `count`=0, `memReq`=0, `memAddr`/`memData`/`memMask`=0 (all slots cleared), `loadHit`=0, `loadConflict`=0, `loadHitData`=0, `drained`=0, state RUN.
- A push while `storeReady`=0 is dropped. Upstream must hold the store, so this is an illegal case.

## Timing
- Write latency: a store pushed at edge N appears on `memReq`/`memAddr` in the cycle after edge N (registered state).
- Throughput: one pop per cycle while `memAck` is held high. One push per cycle while not full.
- Full: with `count`=`DEPTH`, `storeReady`=0 even if `memAck` is high that cycle. There is no pass-through, and `storeReady` depends only on registered state.
- Wrap-around: a push at tail=`DEPTH`-1 writes slot `DEPTH`-1, and the tail becomes 0.
- A load conflicting with the head entry while that entry is being acked still reports `loadConflict`. It clears in the next cycle.
- Reset asserted mid-transfer: all entries are discarded and `memReq` drops immediately (asynchronously). Memory must ignore a partial handshake.

## Test plan
- Reset then idle: `count`=0, `memReq`=0, `storeReady`=1. Push addr 0x100, data 0xDEADBEEF, mask 0xF; next cycle `memReq`=1 and `memAddr`=0x100. Ack → `empty`=1.
- Fill to 4 entries with `memAck`=0: `storeReady`=0 after the 4th push and a 5th push is dropped. Then ack 4 cycles in a row → pops come out in order, and `count` steps 4, 3, 2, 1, 0.
- Wrap: run 6 push/pop pairs with simultaneous push and ack → `count` stays at 1, pointers wrap, and the data order is preserved.
- Forwarding: push 0x200/0x11111111/0xF, then 0x200/0x22222222/0xF. Load 0x202 with mask 0xF → `loadHit`=1, data 0x22222222. Push 0x300 with mask 0x3, then load 0x300 with mask 0xF → `loadConflict`=1.
- Drain: with 3 entries pending, pulse `flushReq` → `storeReady`=0 until empty. `drained` is high for exactly 1 cycle after the last ack.
- Reset mid-operation: with 2 entries and `memReq`=1, assert `resetIn`=0 between edges → `memReq`=0 and `count`=0 immediately.
